int_vector_arbiter: RTL

Parametrised interrupt controller that sits between the peripherals and the CPU's `NMI`/`INT`/`IntAddrLSBs`/`INTACK` interface. It replaces the single hard-wired maskable request with NCH prioritised channels, each with a per-channel edge/level mode, a software-visible enable register (IE) and flag register (IFG), and automatic flag clearing on acknowledge. It also edge-detects and latches a non-maskable request, and presents the winning vector to the CPU in registered form.

---
 rtl/int_vector_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/int_vector_arbiter.sv
// Prioritised interrupt controller. It provides NCH maskable channels plus a
// latched NMI, and presents the winning vector to the CPU as registered outputs.
module int_vector_arbiter #(
  parameter int unsigned    NCH          = 8,
  parameter logic [NCH-1:0] EDGE_MASK    = {NCH{1'b1}},
  parameter logic [NCH-1:0] AUTOCLR_MASK = {NCH{1'b1}},
  parameter logic [5:0]     VEC_TOP      = 6'h3D,
  parameter logic [5:0]     NMI_VEC      = 6'h3E,
  parameter logic [15:0]    REG_BASE     = 16'h0100
) (
  input  logic           MCLK,
  input  logic           reset,
  input  logic [NCH-1:0] irq_in,
  input  logic           nmi_in,
  input  logic           INTACK,
  input  logic [15:0]    reg_addr,
  input  logic [15:0]    reg_wdata,
  input  logic           reg_we,
  output logic [15:0]    reg_rdata,
  output logic           INT,
  output logic           NMI,
  output logic [5:0]     IntAddrLSBs
);

  localparam int unsigned  SEL_W    = 4;
  localparam logic [15:0]  IE_ADDR  = REG_BASE;
  localparam logic [15:0]  IFG_ADDR = REG_BASE + 16'd2;
  localparam logic [5:0]   NO_VEC   = 6'h3F;

  logic [NCH-1:0]   ie_q, ie_d;
  logic [NCH-1:0]   ifg_q, ifg_d;
  logic [NCH-1:0]   irq_prev_q;
  logic             nmi_prev_q;
  logic             nmi_pend_q, nmi_pend_d;
  logic             sel_nmi_q, sel_nmi_d;
  logic [SEL_W-1:0] sel_ch_q, sel_ch_d;
  logic             int_q, int_d;
  logic             nmi_out_q, nmi_out_d;
  logic [5:0]       vec_q, vec_d;

  logic [NCH-1:0]   set_c;
  logic [NCH-1:0]   pend_c;
  logic [SEL_W-1:0] sel_ch_c;
  logic [5:0]       vec_c;
  logic             ack_c;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Next-state: flag sets, arbitration, acknowledge and register writes.
  always_comb begin
    ie_d       = ie_q;
    ifg_d      = ifg_q;
    nmi_pend_d = nmi_pend_q;
    sel_nmi_d  = sel_nmi_q;
    sel_ch_d   = sel_ch_q;
    int_d      = int_q;
    nmi_out_d  = nmi_out_q;
    vec_d      = vec_q;
    sel_ch_c   = '0;
    vec_c      = NO_VEC;

    set_c  = (irq_in & ~irq_prev_q & EDGE_MASK) | (irq_in & ~EDGE_MASK);
    pend_c = ifg_q & ie_q;

    // Descending scan so the lowest pending index is the last to be written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_c[i]) begin
        sel_ch_c = SEL_W'(i);
        vec_c    = VEC_TOP - 6'(i);
      end
    end
    if (nmi_pend_q) vec_c = NMI_VEC;

    // An acknowledge only counts when something is actually being presented.
    ack_c = INTACK & (int_q | nmi_q_w());

    if (reg_we && reg_addr == IE_ADDR)  ie_d  = reg_wdata[NCH-1:0];
    if (reg_we && reg_addr == IFG_ADDR) ifg_d = reg_wdata[NCH-1:0];
    for (int i = 0; i < NCH; i++) begin
      if (ack_c && !sel_nmi_q && sel_ch_q == SEL_W'(i) && AUTOCLR_MASK[i])
        ifg_d[i] = 1'b0;
    end
    ifg_d = ifg_d | set_c;

    if (ack_c && sel_nmi_q)         nmi_pend_d = 1'b0;
    if (nmi_in && !nmi_prev_q)      nmi_pend_d = 1'b1;

    if (!ack_c) begin
      int_d     = |pend_c;
      nmi_out_d = nmi_pend_q;
      vec_d     = vec_c;
      sel_nmi_d = nmi_pend_q;
      sel_ch_d  = sel_ch_c;
    end
  end

  function automatic logic nmi_q_w();
    return nmi_out_q;
  endfunction

  always_ff @(posedge MCLK) begin
    if (reset) begin
      ie_q       <= '0;
      ifg_q      <= '0;
      irq_prev_q <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      sel_nmi_q  <= 1'b0;
      sel_ch_q   <= '0;
      int_q      <= 1'b0;
      nmi_out_q  <= 1'b0;
      vec_q      <= NO_VEC;
    end else begin
      ie_q       <= ie_d;
      ifg_q      <= ifg_d;
      irq_prev_q <= irq_in;
      nmi_prev_q <= nmi_in;
      nmi_pend_q <= nmi_pend_d;
      sel_nmi_q  <= sel_nmi_d;
      sel_ch_q   <= sel_ch_d;
      int_q      <= int_d;
      nmi_out_q  <= nmi_out_d;
      vec_q      <= vec_d;
    end
  end

  // Register read port, zero-extended.
  always_comb begin
    reg_rdata = '0;
    if (reg_addr == IE_ADDR)  reg_rdata = 16'(ie_q);
    if (reg_addr == IFG_ADDR) reg_rdata = 16'(ifg_q);
  end

  assign INT         = int_q;
  assign NMI         = nmi_out_q;
  assign IntAddrLSBs = vec_q;

endmodule
